// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_pkg
//  Description : Shared types and constants for the vending machine readout.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    localparam int VAL_W    = 14;
    localparam int MAX_VAL  = 9999;
    localparam int N_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cbcd_state_t;

endpackage : vending_pkg
`default_nettype wire

// File: rtl/bcd_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_adjust
//  Description : Double-dabble nibble correction; adds 3 to nibbles >= 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_adjust
    import vending_pkg::*;
(
    input  bcd_t nib_in,
    output bcd_t nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule : bcd_adjust
`default_nettype wire

// File: rtl/credit_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : credit_bcd
//  Description : Iterative binary-to-BCD converter with start/busy/done
//                handshake, saturation and a single pending-request slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_bcd #(
    parameter int VAL_W   = vending_pkg::VAL_W,
    parameter int MAX_VAL = vending_pkg::MAX_VAL
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [VAL_W-1:0]   value,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output vending_pkg::bcd_t  dig1,
    output vending_pkg::bcd_t  dig2,
    output vending_pkg::bcd_t  dig3,
    output vending_pkg::bcd_t  dig4
);

    import vending_pkg::*;

    localparam int                 CNT_W = $clog2(VAL_W);
    localparam int                 BCD_W = N_DIGITS * 4;
    localparam logic [VAL_W-1:0]   MAX_V = VAL_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(VAL_W - 1);

    cbcd_state_t        state;
    logic [VAL_W-1:0]   bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic               pend;
    logic [VAL_W-1:0]   pend_val;

    // A fresh start always beats an older pending request.
    logic [VAL_W-1:0]   load_src;
    logic               load_sat;
    logic [VAL_W-1:0]   load_bin;

    assign load_src = start ? value : pend_val;
    assign load_sat = (load_src > MAX_V);
    assign load_bin = load_sat ? MAX_V : load_src;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
        bcd_adjust u_adj (
            .nib_in  (bcd[4*i +: 4]),
            .nib_out (adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            pend     <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dig1     <= '0;
            dig2     <= '0;
            dig3     <= '0;
            dig4     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= load_bin;
                        bcd   <= '0;
                        sat   <= load_sat;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    bcd <= {adj[BCD_W-2:0], bin[VAL_W-1]};
                    bin <= {bin[VAL_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= COMMIT;
                    end
                    if (start) begin
                        pend     <= 1'b1;
                        pend_val <= value;
                    end
                end

                COMMIT: begin
                    dig1 <= bcd[3:0];
                    dig2 <= bcd[7:4];
                    dig3 <= bcd[11:8];
                    dig4 <= bcd[15:12];
                    ovf  <= sat;
                    done <= 1'b1;
                    pend <= 1'b0;
                    if (start || pend) begin
                        bin   <= load_bin;
                        bcd   <= '0;
                        sat   <= load_sat;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : credit_bcd
`default_nettype wire
